ps2_rx_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver that runs entirely in the system `clk` domain. PS2_KBCLK is synchronised and edge-detected rather than used as a clock. It frames 11-bit PS/2 packets and assembles multi-byte scan codes (E0/F0/E1 prefixes, 8-byte Pause sequence). Complete codes are pushed into a small show-ahead FIFO with a valid/ready output. A 16-bit `hex` output keeps driving the seven-segment display path.

---
 rtl/ps2_rx_fifo.sv | 179 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised frame decoder, multi-byte scan-code assembler and show-ahead output FIFO.
// Define PS2_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYC cycles.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES = 2,
  parameter int CODE_BYTES  = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PS2_KBCLK,
  input  logic                          PS2_KBDAT,
  output logic [8*CODE_BYTES-1:0]       code_data,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [15:0]                   hex,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = 8 * CODE_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, kb_clk, kb_dat, fe;
  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   parity_bit;
  logic [CW-1:0]          seq, seq_next;
  logic                   asm_busy, pause_active;
  logic [2:0]             pause_cnt;
  logic                   stop_fe, bad_stop, bad_par, byte_ok, push, timeout;
  logic [CW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   full, pop, wr_en;

  // Lines idle high, so the synchronisers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_KBCLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_KBDAT};
      clk_prev <= kb_clk;
    end
  end

  assign kb_clk   = clk_sync[SYNC_STAGES-1];
  assign kb_dat   = dat_sync[SYNC_STAGES-1];
  assign fe       = clk_prev & ~kb_clk;
  assign stop_fe  = fe && (state == STOP);
  assign bad_stop = stop_fe && !kb_dat;
  assign bad_par  = stop_fe && kb_dat && !(^{shift_reg, parity_bit});
  assign byte_ok  = stop_fe && kb_dat && (^{shift_reg, parity_bit});

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || fe || state == IDLE) to_cnt <= '0;
    else                            to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = !fe && (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst || timeout) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else if (fe) begin
      case (state)
        IDLE: if (!kb_dat) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
        DATA: begin
          shift_reg <= {kb_dat, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= PARITY;
        end
        PARITY: begin
          parity_bit <= kb_dat;
          state      <= STOP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prefix bytes and all but the last Pause byte are held; anything else completes a code.
  always_comb begin
    seq_next = {seq[CW-9:0], shift_reg};
    push     = 1'b0;
    if (byte_ok) begin
      if (pause_active)
        push = (pause_cnt == 3'd1);
      else if (!(shift_reg == 8'hE1 && !asm_busy) && shift_reg != 8'hE0 && shift_reg != 8'hF0)
        push = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || timeout || bad_par) begin
      seq          <= '0;
      asm_busy     <= 1'b0;
      pause_active <= 1'b0;
      pause_cnt    <= '0;
    end else if (byte_ok) begin
      if (push) begin
        seq          <= '0;
        asm_busy     <= 1'b0;
        pause_active <= 1'b0;
        pause_cnt    <= '0;
      end else begin
        seq      <= seq_next;
        asm_busy <= 1'b1;
        if (pause_active) begin
          pause_cnt <= pause_cnt - 3'd1;
        end else if (shift_reg == 8'hE1 && !asm_busy) begin
          pause_active <= 1'b1;
          pause_cnt    <= 3'd7;
        end
      end
    end
  end

  assign full  = (count == FULL_LVL);
  assign pop   = code_valid & code_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hex        <= 16'h0000;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bad_par)   hex <= 16'hEEEE;
      else if (push) hex <= seq_next[15:0];
      err_parity <= bad_par;
      err_frame  <= bad_stop | timeout;
      overflow   <= push && full && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= seq_next;
  end

  assign code_valid = (count != '0);
  assign code_data  = code_valid ? mem[rd_ptr] : '0;
  assign fifo_level = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed PS/2 frames with a scoreboard queue of expected codes.
module tb_ps2_rx_fifo;

  localparam int TO = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PS2_KBCLK = 1'b1;
  logic        PS2_KBDAT = 1'b1;
  logic [23:0] code_data;
  logic        code_valid;
  logic        code_ready = 1'b0;
  logic [15:0] hex;
  logic        err_parity, err_frame, overflow;
  logic [2:0]  fifo_level;

  int n_cmp = 0, n_fail = 0;
  int n_pops = 0, n_par = 0, n_frm = 0, n_ovf = 0;
  int base;
  logic [23:0] exp_q[$];

  ps2_rx_fifo #(.SYNC_STAGES(2), .CODE_BYTES(3), .FIFO_DEPTH(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .PS2_KBCLK(PS2_KBCLK), .PS2_KBDAT(PS2_KBDAT),
    .code_data(code_data), .code_valid(code_valid), .code_ready(code_ready),
    .hex(hex), .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2Bit(input logic b);
    PS2_KBDAT = b;
    tick(4);
    PS2_KBCLK = 1'b0;
    tick(4);
    PS2_KBCLK = 1'b1;
  endtask

  // pop_on_stop raises code_ready for exactly the cycle whose closing edge performs the push.
  task automatic applyStimulus(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                               input bit pop_on_stop);
    logic p;
    p = ~(^d) ^ bad_par;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(d[i]);
    ps2Bit(p);
    PS2_KBDAT = ~bad_stop;
    tick(4);
    PS2_KBCLK = 1'b0;
    if (pop_on_stop) begin
      tick(2);
      code_ready = 1'b1;
      tick(1);
      code_ready = 1'b0;
      tick(1);
    end else begin
      tick(4);
    end
    PS2_KBCLK = 1'b1;
    PS2_KBDAT = 1'b1;
    tick(6);
  endtask

  task automatic partialFrame();
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b1);
    PS2_KBDAT = 1'b1;
  endtask

  task automatic drain();
    code_ready = 1'b1;
    tick(8);
    code_ready = 1'b0;
    checkOutput("drain_level", 32'(fifo_level), 32'd0);
  endtask

  // Scoreboard side: every handshake must match the oldest expected code.
  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid && code_ready) begin
        n_pops++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("[TB] FAIL unexpected_pop: observed=%0h expected=none", code_data);
        end
        if (exp_q.size() != 0) checkOutput("pop_data", 32'(code_data), 32'(exp_q.pop_front()));
      end
      if (err_parity) n_par++;
      if (err_frame)  n_frm++;
      if (overflow)   n_ovf++;
    end
  end

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    // Reset values
    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("rst_valid", 32'(code_valid), 32'd0);
    checkOutput("rst_data", 32'(code_data), 32'd0);
    checkOutput("rst_hex", 32'(hex), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_pulses", 32'({err_parity, err_frame, overflow}), 32'd0);

    // Single-byte code consumed immediately
    code_ready = 1'b1;
    exp_q.push_back(24'h00001C);
    base = n_pops;
    applyStimulus(8'h1C, 0, 0, 0);
    checkOutput("single_pops", 32'(n_pops - base), 32'd1);
    checkOutput("single_hex", 32'(hex), 32'h001C);
    checkOutput("single_level", 32'(fifo_level), 32'd0);
    code_ready = 1'b0;

    // E0 F0 prefixes are held until the final byte
    exp_q.push_back(24'hE0F075);
    applyStimulus(8'hE0, 0, 0, 0);
    checkOutput("pfx_e0_level", 32'(fifo_level), 32'd0);
    applyStimulus(8'hF0, 0, 0, 0);
    checkOutput("pfx_f0_level", 32'(fifo_level), 32'd0);
    applyStimulus(8'h75, 0, 0, 0);
    checkOutput("pfx_level", 32'(fifo_level), 32'd1);
    checkOutput("pfx_hex", 32'(hex), 32'hF075);
    drain();

    // Pause sequence pushes only on the 8th byte
    exp_q.push_back(24'h14F077);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(pause_seq[i], 0, 0, 0);
      checkOutput("pause_hold", 32'(fifo_level), 32'd0);
    end
    applyStimulus(pause_seq[7], 0, 0, 0);
    checkOutput("pause_level", 32'(fifo_level), 32'd1);
    checkOutput("pause_hex", 32'(hex), 32'hF077);
    drain();

    // Parity error clears the assembler, stop error keeps it
    base = n_par;
    applyStimulus(8'hE0, 0, 0, 0);
    applyStimulus(8'h1C, 1, 0, 0);
    checkOutput("par_pulse", 32'(n_par - base), 32'd1);
    checkOutput("par_hex", 32'(hex), 32'hEEEE);
    checkOutput("par_level", 32'(fifo_level), 32'd0);
    exp_q.push_back(24'h00001C);
    applyStimulus(8'h1C, 0, 0, 0);
    checkOutput("par_after", 32'(fifo_level), 32'd1);
    drain();
    base = n_frm;
    applyStimulus(8'hE0, 0, 0, 0);
    applyStimulus(8'h1C, 0, 1, 0);
    checkOutput("stop_pulse", 32'(n_frm - base), 32'd1);
    checkOutput("stop_level", 32'(fifo_level), 32'd0);
    exp_q.push_back(24'h00E01C);
    applyStimulus(8'h1C, 0, 0, 0);
    checkOutput("stop_after", 32'(fifo_level), 32'd1);
    drain();

    // Overflow, then simultaneous push and pop while full
    exp_q.push_back(24'h000015);
    exp_q.push_back(24'h00001D);
    exp_q.push_back(24'h000024);
    exp_q.push_back(24'h00002D);
    applyStimulus(8'h15, 0, 0, 0);
    applyStimulus(8'h1D, 0, 0, 0);
    applyStimulus(8'h24, 0, 0, 0);
    applyStimulus(8'h2D, 0, 0, 0);
    checkOutput("full_level", 32'(fifo_level), 32'd4);
    base = n_ovf;
    applyStimulus(8'h2C, 0, 0, 0);
    checkOutput("ovf_pulse", 32'(n_ovf - base), 32'd1);
    checkOutput("ovf_level", 32'(fifo_level), 32'd4);
    checkOutput("ovf_hex", 32'(hex), 32'h002C);
    exp_q.push_back(24'h00001C);
    applyStimulus(8'h1C, 0, 0, 1);
    checkOutput("pp_level", 32'(fifo_level), 32'd4);
    checkOutput("pp_no_ovf", 32'(n_ovf - base), 32'd1);
    drain();
    checkOutput("ovf_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef PS2_TIMEOUT_EN
    // Stalled frame is aborted once, then reception recovers
    base = n_frm;
    partialFrame();
    tick(TO + 20);
    checkOutput("to_pulse", 32'(n_frm - base), 32'd1);
    code_ready = 1'b1;
    exp_q.push_back(24'h00001C);
    applyStimulus(8'h1C, 0, 0, 0);
    code_ready = 1'b0;
    checkOutput("to_recover", 32'(exp_q.size()), 32'd0);
`endif

    // Reset mid-frame with a non-empty FIFO
    applyStimulus(8'h29, 0, 0, 0);
    checkOutput("pre_rst_level", 32'(fifo_level), 32'd1);
    partialFrame();
`ifndef PS2_TIMEOUT_EN
    base = n_frm;
    tick(TO + 20);
    checkOutput("no_to_pulse", 32'(n_frm - base), 32'd0);
`endif
    rst = 1'b1;
    tick(1);
    checkOutput("mid_rst_valid", 32'(code_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(code_data), 32'd0);
    checkOutput("mid_rst_hex", 32'(hex), 32'd0);
    checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_pulses", 32'({err_parity, err_frame, overflow}), 32'd0);
    rst = 1'b0;
    tick(2);
    code_ready = 1'b1;
    exp_q.push_back(24'h00001C);
    applyStimulus(8'h1C, 0, 0, 0);
    code_ready = 1'b0;
    checkOutput("post_rst_hex", 32'(hex), 32'h001C);
    checkOutput("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
